// File: rtl/data_mem_arbiter_if.sv
// Requester handshake and data-memory port bundle for data_mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface data_mem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_sr;
  logic [31:0] mem_write_data;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_read_data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_sr, mem_write_data, mem_memRead, mem_memWrite
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_sr, mem_write_data, mem_memRead, mem_memWrite
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester sequencer in front of the single-port data memory: one
// transaction in flight, programmable access length, registered outputs.
module data_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned ADDR_BITS   = 10
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic        oor_q, oor_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [31:0] mem_sr_q, mem_sr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;

  logic        pick_valid;
  logic        pick;
  logic [31:0] rdata_new;

  always_comb begin
    pick_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) pick = RR_EN ? ~last_gnt_q : 1'b0;
    else                      pick = bus.req1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    we_d       = we_q;
    oor_d      = oor_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = err0_q;
    err1_d     = err1_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_sr_d   = '0;
    mem_wd_d   = '0;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    rdata_new  = (we_q || oor_q) ? '0 : bus.mem_read_data;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d      = pick;
          last_gnt_d = pick;
          we_d       = pick ? bus.we1    : bus.we0;
          addr_d     = pick ? bus.addr1  : bus.addr0;
          wdata_d    = pick ? bus.wdata1 : bus.wdata0;
          oor_d      = (addr_d >> ADDR_BITS) != 32'd0;
          cnt_d      = CNT_INIT;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (sel_q) begin
            done1_d  = 1'b1;
            err1_d   = oor_q;
            rdata1_d = rdata_new;
          end else begin
            done0_d  = 1'b1;
            err0_d   = oor_q;
            rdata0_d = rdata_new;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Memory strobes are registered from the next-cycle view so they line up
    // with ACCESS cycles; memWrite only in the cycle whose counter reaches 0.
    if (state_d == ACCESS) begin
      mem_sr_d = addr_d;
      mem_wd_d = wdata_d;
      mem_rd_d = ~we_d & ~oor_d;
      mem_wr_d = we_d & ~oor_d & (cnt_d == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_sr_q   <= '0;
      mem_wd_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_sr_q   <= mem_sr_d;
      mem_wd_q   <= mem_wd_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.done0          = done0_q;
  assign bus.done1          = done1_q;
  assign bus.err0           = err0_q;
  assign bus.err1           = err1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.mem_sr         = mem_sr_q;
  assign bus.mem_write_data = mem_wd_q;
  assign bus.mem_memRead    = mem_rd_q;
  assign bus.mem_memWrite   = mem_wr_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sequencing controller and two-way arbiter in front of the single-port data memory (data_mem_mod).
- Shares the memory between requester 0 (processor load/store stage) and requester 1 (test/boot loader port).
- Per transaction: latches the request, drives the memory port for a programmable number of access cycles, registers the read data, and returns a one-cycle done with optional out-of-range error.
- Exactly one transaction is in flight at any time.

Parameters:
- WAIT_CYCLES, 1, cycles the memory port is driven per access (1..15); memWrite is strobed only in the last one.
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, requester 0 always wins.
- ADDR_BITS, 10, implemented address bits; any set bit in addr[31:ADDR_BITS] is out-of-range.

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  request, level; held with its fields until the matching done
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  32 each  word address
- wdata0, wdata1  in  32 each  write data
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted, fields latched
- done0, done1  out  1 each  one-cycle pulse: transaction complete
- err0, err1  out  1 each  valid with done: address out of range
- rdata0, rdata1  out  32 each  read data, valid while done is high
- mem_sr  out  32  to memory sr
- mem_write_data  out  32  to memory write_data
- mem_memRead  out  1  to memory memRead
- mem_memWrite  out  1  to memory memWrite
- mem_read_data  in  32  from memory read_data (combinational read)

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (sync, at the edge): state=IDLE; wait counter=0; last_gnt=1, so requester 0 wins the first tie.
  - All outputs 0: gnt*, done*, err*, rdata*, mem_*.
  - Reset wins over every other event in the same cycle.
- IDLE, no req: all mem_* outputs 0.
- IDLE, request selection:
  - One req high: select that requester.
  - Both high, RR_EN=1: select !last_gnt.
  - Both high, RR_EN=0: select requester 0.
- IDLE, on selection at edge k:
  - Latch we, addr and wdata of the selected requester; set last_gnt.
  - Go to ACCESS with counter=WAIT_CYCLES-1.
  - gnt of the selected requester is high during cycle k+1 only.
- ACCESS, address in range:
  - mem_sr = latched addr; mem_write_data = latched wdata.
  - mem_memRead = !we for every ACCESS cycle.
  - mem_memWrite = we only while counter==0, giving exactly one write edge.
  - Counter decrements each cycle.
  - At the edge with counter==0: rdata_sel <= mem_read_data for a read, 0 for a write; go to RESP.
- ACCESS, address out of range: mem_memRead and mem_memWrite stay 0 for the whole ACCESS phase; rdata=0, err=1 on exit. The access cycles are still counted.
- RESP: done (and err, if flagged) of the served requester is high for exactly this cycle; next state IDLE.
- Latency: req sampled at edge k → done during cycle k+WAIT_CYCLES+1. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- rdata/err of each requester hold their value until that requester's next RESP.
- Requester protocol:
  - Must deassert req at the edge that ends its done cycle, unless it issues a new transaction.
  - A req still high in IDLE is a new request.
  - Changing fields between gnt and done is ignored, because they are latched.
- The non-served requester keeps waiting with gnt/done low; no request is dropped.
- A req that drops before its gnt withdraws the request; a req that drops after gnt does not cancel the transaction.
- Reset during ACCESS:
  - mem_memWrite is registered low at the reset edge, so no partial write after reset.
  - The in-flight transaction is discarded with no done.

Test Plan:
- Single read: preload mem[5]=32'hDEADBEEF; req0, we0=0, addr0=5, WAIT_CYCLES=1 → gnt0 at cycle 1, done0 at cycle 2, rdata0=DEADBEEF, err0=0, mem_memWrite never high.
- Write then read back, WAIT_CYCLES=3: req1 write addr 10 data 32'h12345678 → mem_memWrite high only in the third ACCESS cycle, done1 at cycle 4; then req1 read addr 10 → rdata1=12345678.
- Contention, RR_EN=1: req0 and req1 high continuously, each re-requesting after its done → grants alternate 0,1,0,1; with RR_EN=0 → 0,0,0 and req1 starved.
- Out-of-range: req0 read addr 32'h00000400 → mem_memRead/mem_memWrite stay 0, done0 with err0=1, rdata0=0; the next in-range read clears err0.
- Reset mid-write: assert reset during the first ACCESS cycle of a WAIT_CYCLES=2 write to addr 3 → no memWrite pulse, mem[3] unchanged, no done, state IDLE, all outputs 0 on the cycle after reset.
- Field change after grant: change addr0 from 7 to 8 the cycle after gnt0 → access still targets mem_sr=7.
